guess_game_ctrl: RTL and testbench
==================================

Name: guess_game_ctrl

Overview:
Sequential controller for the number-guessing lab built around the team's 4-bit magnitude comparator. It holds a secret target and drives it onto the comparator's A input. It registers each player guess onto the B input. It then consumes the comparator's 3-bit active-low result code to produce hints, an attempt count and win/lose status. It sits between the board switches/buttons (upstream) and the LED/7-seg display logic (downstream).

Parameters:
WIDTH, 4, width of target, guess and comparator operands
MAX_TRIES, 7, wrong guesses allowed before LOSE (1..7)
CNT_W, 3, width of tries counter; must hold MAX_TRIES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_target  in  1  one-cycle pulse; load target_in and start a new game
target_in  in  WIDTH  secret value
guess_valid  in  1  guess offered this cycle
guess_ready  out  1  high only in ARMED; guess accepted when valid && ready
guess_in  in  WIDTH  player guess
cmp_a  out  WIDTH  comparator A (registered target)
cmp_b  out  WIDTH  comparator B (registered guess)
cmp_y  in  3  comparator result, active-low one-hot: 3'b011 A>B, 3'b110 A<B, 3'b101 A==B
hint  out  2  00 none, 01 guess too low, 10 guess too high, 11 illegal cmp_y
tries  out  CNT_W  wrong guesses so far, saturating
win  out  1  level, high in WIN
lose  out  1  level, high in LOSE

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n); all state is cleared on the falling edge of rst_n, independent of clk.
- Reset values: state=IDLE, cmp_a=0, cmp_b=0, hint=00, tries=0, win=0, lose=0, guess_ready=0.
- States: IDLE, ARMED, EVAL, WIN, LOSE. Encoding is a localparam in the package.
- IDLE: waits for load_target.
- Any state, load_target=1:
  - cmp_a<=target_in, tries<=0, hint<=00, win/lose<=0, state<=ARMED.
  - load_target has priority over guess_valid in the same cycle; that guess is dropped.
- ARMED: guess_ready=1. When guess_valid=1: cmp_b<=guess_in, state<=EVAL.
- EVAL: one cycle, guess_ready=0. cmp_y is sampled (combinational settle through the external comparator) and decoded:
  - 3'b101: state<=WIN, hint<=00; tries unchanged.
  - 3'b011 (target>guess): hint<=01, tries<=tries+1.
  - 3'b110 (target<guess): hint<=10, tries<=tries+1.
  - After a 01/10 result: if tries+1==MAX_TRIES then state<=LOSE, else state<=ARMED.
  - Any other code: hint<=11, tries unchanged, state<=ARMED. The guess is not counted.
- Latency: guess accepted at edge N; cmp_b valid after N; hint/tries/win/lose updated at edge N+1. That is 2 cycles from guess_valid sample to visible result.
- WIN/LOSE: guesses are ignored (guess_ready=0). Outputs hold until load_target or reset.
- tries saturates at MAX_TRIES; it never wraps.
- Reset mid-EVAL: abort immediately to reset values; the pending guess is lost.
- All outputs are registered except guess_ready, which is decoded from state.

Decomposition:
- Package guess_game_pkg:
  - state localparams.
  - cmp_y codes CMP_GT=3'b011, CMP_LT=3'b110, CMP_EQ=3'b101.
  - hint codes HINT_NONE/LOW/HIGH/ERR.
- One natural sub-module: cmp_decode, a combinational decode of cmp_y to {gt, lt, eq, illegal}. It is reusable by the display logic.
- The comparator itself stays external and is instantiated by the top level.

Test Plan:
- Reset, then load_target=9, then guess 9 -> two cycles after guess_valid: win=1, hint=00, tries=0. A further guess_valid is ignored (guess_ready=0).
- target=9, guesses 3 then 12 -> hint=01 after the first guess, hint=10 after the second, tries=2, state ARMED.
- MAX_TRIES=7, target=5, seven guesses of 0 -> tries=7, lose=1 after the seventh. An eighth guess is ignored and tries stays 7.
- Force cmp_y=3'b000 during EVAL -> hint=11, tries unchanged, guess_ready high the next cycle.
- load_target=2 and guess_valid=1 in the same cycle while in ARMED -> cmp_a=2, tries=0, guess dropped, state ARMED.
- Assert rst_n=0 mid-EVAL, asynchronously between clock edges -> all outputs 0 immediately. After release, IDLE with guess_ready=0.

Source files
------------

// File: rtl/guess_game_pkg.sv
// rtl/guess_game_pkg.sv - shared encodings for the number-guessing controller
package guess_game_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_EVAL  = 3'd2;
    localparam logic [2:0] ST_WIN   = 3'd3;
    localparam logic [2:0] ST_LOSE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        ARMED = ST_ARMED,
        EVAL  = ST_EVAL,
        WIN   = ST_WIN,
        LOSE  = ST_LOSE
    } state_t;

    // Comparator result codes are active-low one-hot.
    localparam logic [2:0] CMP_GT = 3'b011;
    localparam logic [2:0] CMP_LT = 3'b110;
    localparam logic [2:0] CMP_EQ = 3'b101;

    localparam logic [1:0] HINT_NONE = 2'b00;
    localparam logic [1:0] HINT_LOW  = 2'b01;
    localparam logic [1:0] HINT_HIGH = 2'b10;
    localparam logic [1:0] HINT_ERR  = 2'b11;

endpackage

// File: rtl/cmp_decode.sv
// rtl/cmp_decode.sv - combinational decode of the comparator result code
module cmp_decode
    import guess_game_pkg::*;
(
    input  logic [2:0] cmp_y,
    output logic       gt,
    output logic       lt,
    output logic       eq,
    output logic       illegal
);

    assign gt      = (cmp_y == CMP_GT);
    assign lt      = (cmp_y == CMP_LT);
    assign eq      = (cmp_y == CMP_EQ);
    assign illegal = !(gt || lt || eq);

endmodule

// File: rtl/guess_game_ctrl.sv
// rtl/guess_game_ctrl.sv - game FSM driving an external magnitude comparator
module guess_game_ctrl
    import guess_game_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_TRIES = 7,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_target,
    input  logic [WIDTH-1:0] target_in,
    input  logic             guess_valid,
    output logic             guess_ready,
    input  logic [WIDTH-1:0] guess_in,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic [2:0]       cmp_y,
    output logic [1:0]       hint,
    output logic [CNT_W-1:0] tries,
    output logic             win,
    output logic             lose
);

    state_t           state;
    logic             gt, lt, eq, illegal;
    logic [CNT_W-1:0] tries_inc;

    cmp_decode u_cmp_decode (
        .cmp_y   (cmp_y),
        .gt      (gt),
        .lt      (lt),
        .eq      (eq),
        .illegal (illegal)
    );

    assign guess_ready = (state == ARMED);
    assign tries_inc   = tries + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cmp_a <= '0;
            cmp_b <= '0;
            hint  <= HINT_NONE;
            tries <= '0;
            win   <= 1'b0;
            lose  <= 1'b0;
        end else if (load_target) begin
            // A new game always wins over a guess offered in the same cycle.
            state <= ARMED;
            cmp_a <= target_in;
            hint  <= HINT_NONE;
            tries <= '0;
            win   <= 1'b0;
            lose  <= 1'b0;
        end else begin
            case (state)
                ARMED: begin
                    if (guess_valid) begin
                        cmp_b <= guess_in;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    case ({gt, lt, eq, illegal})
                        4'b0010: begin
                            hint  <= HINT_NONE;
                            win   <= 1'b1;
                            state <= WIN;
                        end
                        4'b1000, 4'b0100: begin
                            hint <= gt ? HINT_LOW : HINT_HIGH;
                            if (tries != CNT_W'(MAX_TRIES))
                                tries <= tries_inc;
                            if (tries_inc >= CNT_W'(MAX_TRIES)) begin
                                lose  <= 1'b1;
                                state <= LOSE;
                            end else begin
                                state <= ARMED;
                            end
                        end
                        default: begin
                            // Garbage from the comparator is flagged but not charged to the player.
                            hint  <= HINT_ERR;
                            state <= ARMED;
                        end
                    endcase
                end
                WIN, LOSE, IDLE: state <= state;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb/tb_guess_game_ctrl.sv - scoreboard bench for guess_game_ctrl
module tb_guess_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_target = 1'b0;
    logic [3:0] target_in = '0;
    logic       guess_valid = 1'b0;
    logic       guess_ready;
    logic [3:0] guess_in = '0;
    logic [3:0] cmp_a, cmp_b;
    logic [2:0] cmp_y;
    logic [1:0] hint;
    logic [2:0] tries;
    logic       win, lose;

    logic       force_en = 1'b0;
    int         tests = 0;
    int         failed = 0;

    typedef struct {
        logic [3:0] b;
        logic [1:0] hint;
        logic [2:0] tries;
        logic       win;
        logic       lose;
        logic       ready;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    // Behavioural stand-in for the external magnitude comparator.
    always_comb begin
        if (force_en)            cmp_y = 3'b000;
        else if (cmp_a > cmp_b)  cmp_y = 3'b011;
        else if (cmp_a < cmp_b)  cmp_y = 3'b110;
        else                     cmp_y = 3'b101;
    end

    guess_game_ctrl #(.WIDTH(4), .MAX_TRIES(7), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_target (load_target),
        .target_in   (target_in),
        .guess_valid (guess_valid),
        .guess_ready (guess_ready),
        .guess_in    (guess_in),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .cmp_y       (cmp_y),
        .hint,
        .tries       (tries),
        .win         (win),
        .lose        (lose)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at one negedge has cmp_b one cycle later and results two cycles later.
    initial begin
        int   pend;
        exp_t e;
        pend = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (q.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                        pend = 0;
                    end else if (pend == 1) begin
                        chk("sb_cmp_b", cmp_b, q[0].b);
                    end else begin
                        e = q.pop_front();
                        chk("sb_hint", hint, e.hint);
                        chk("sb_tries", tries, e.tries);
                        chk("sb_win", win, e.win);
                        chk("sb_lose", lose, e.lose);
                        chk("sb_ready", guess_ready, e.ready);
                    end
                end
                if (guess_valid && guess_ready && !load_target)
                    pend = 2;
            end
        end
    end

    task automatic do_load(input logic [3:0] t);
        load_target = 1'b1;
        target_in   = t;
        @(posedge clk); #1;
        load_target = 1'b0;
    endtask

    task automatic do_guess(input logic [3:0] g, input logic [1:0] h, input logic [2:0] tr,
                            input logic w, input logic l, input logic r);
        exp_t e;
        e.b = g; e.hint = h; e.tries = tr; e.win = w; e.lose = l; e.ready = r;
        q.push_back(e);
        guess_valid = 1'b1;
        guess_in    = g;
        @(posedge clk); #1;
        guess_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic offer_ignored(input logic [3:0] g);
        guess_valid = 1'b1;
        guess_in    = g;
        repeat (2) @(posedge clk);
        #1;
        guess_valid = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_cmp_a", cmp_a, 0);
        chk("rst_hint", hint, 0);
        chk("rst_tries", tries, 0);
        chk("rst_ready", guess_ready, 0);
        chk("rst_win_lose", {win, lose}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Correct first guess, later guesses ignored.
        do_load(4'd9);
        chk("load_cmp_a", cmp_a, 9);
        chk("load_ready", guess_ready, 1);
        do_guess(4'd9, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0);
        offer_ignored(4'd3);
        chk("win_hold", win, 1);
        chk("win_cmp_b", cmp_b, 9);
        chk("win_ready", guess_ready, 0);

        // Too low then too high.
        do_load(4'd9);
        do_guess(4'd3,  2'b01, 3'd1, 1'b0, 1'b0, 1'b1);
        do_guess(4'd12, 2'b10, 3'd2, 1'b0, 1'b0, 1'b1);

        // Seven misses end in LOSE.
        do_load(4'd5);
        for (int i = 1; i <= 7; i++)
            do_guess(4'd0, 2'b01, 3'(i), 1'b0, i == 7, i != 7);
        offer_ignored(4'd0);
        chk("lose_tries_sat", tries, 7);
        chk("lose_hold", lose, 1);

        // Illegal comparator codes are flagged and not counted.
        do_load(4'd9);
        force_en = 1'b1;
        do_guess(4'd4, 2'b11, 3'd0, 1'b0, 1'b0, 1'b1);
        force_en = 1'b0;
        do_guess(4'd4, 2'b01, 3'd1, 1'b0, 1'b0, 1'b1);
        force_en = 1'b1;
        do_guess(4'd4, 2'b11, 3'd1, 1'b0, 1'b0, 1'b1);
        force_en = 1'b0;

        // load_target beats a simultaneous guess.
        load_target = 1'b1;
        target_in   = 4'd2;
        guess_valid = 1'b1;
        guess_in    = 4'd11;
        @(posedge clk); #1;
        load_target = 1'b0;
        guess_valid = 1'b0;
        chk("prio_cmp_a", cmp_a, 2);
        chk("prio_tries", tries, 0);
        chk("prio_hint", hint, 0);
        chk("prio_cmp_b", cmp_b, 4);
        @(posedge clk); #1;
        chk("prio_ready", guess_ready, 1);

        // Asynchronous reset while the guess is in EVAL.
        guess_valid = 1'b1;
        guess_in    = 4'd7;
        @(posedge clk); #1;
        guess_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cmp_a", cmp_a, 0);
        chk("arst_cmp_b", cmp_b, 0);
        chk("arst_hint_tries", {hint, tries}, 0);
        chk("arst_win_lose", {win, lose}, 0);
        chk("arst_ready", guess_ready, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", guess_ready, 0);
        offer_ignored(4'd6);
        chk("idle_cmp_b", cmp_b, 0);
        chk("idle_hint", hint, 0);

        repeat (3) @(posedge clk);
        chk("sb_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
